// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises CPU/DMA transactions onto one memory bus with per-bank wait states and DMA anti-starvation
module memory_arbiter #(
  parameter int WAIT_BANK0 = 0,
  parameter int WAIT_BANK1 = 0,
  parameter int WAIT_BANK2 = 1,
  parameter int WAIT_BANK3 = 0,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_write_enable,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_ready,
  input  logic        dma_req,
  input  logic [15:0] dma_address,
  input  logic [7:0]  dma_data_in,
  input  logic        dma_write_enable,
  output logic [7:0]  dma_data_out,
  output logic        dma_ready,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_data_out,
  output logic        bus_write_enable,
  input  logic [7:0]  bus_data_in,
  output logic        bus_busy,
  output logic        bus_owner
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
  localparam int WM01 = WAIT_BANK0 > WAIT_BANK1 ? WAIT_BANK0 : WAIT_BANK1;
  localparam int WM23 = WAIT_BANK2 > WAIT_BANK3 ? WAIT_BANK2 : WAIT_BANK3;
  localparam int WMAX = WM01 > WM23 ? WM01 : WM23;
  localparam int WW = WMAX > 0 ? $clog2(WMAX + 1) : 1;
  localparam int SW = STARVE_LIMIT > 3 ? $clog2(STARVE_LIMIT + 1) : 2;
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  logic [1:0] state;
  logic we, first, owner, dma_win;
  logic [WW-1:0] wait_cnt, bank_wait;
  logic [SW-1:0] starve_cnt;
  logic [15:0] win_addr;
  always_comb begin
    dma_win = dma_req & (~cpu_req | (starve_cnt == SLIM));
    win_addr = dma_win ? dma_address : cpu_address;
    bank_wait = win_addr[15] ? (win_addr[14] ? WW'(WAIT_BANK3) : WW'(WAIT_BANK2))
                             : (win_addr[14] ? WW'(WAIT_BANK1) : WW'(WAIT_BANK0));
  end
  assign bus_write_enable = (state == ACCESS) & we & first;
  assign cpu_ready = (state == DONE) & ~owner;
  assign dma_ready = (state == DONE) & owner;
  assign bus_busy = (state == ACCESS) | (state == DONE);
  assign bus_owner = owner;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      we <= 1'b0;
      first <= 1'b0;
      owner <= 1'b0;
      wait_cnt <= '0;
      starve_cnt <= '0;
      bus_address <= '0;
      bus_data_out <= '0;
      cpu_data_out <= '0;
      dma_data_out <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_req | dma_req) begin
          state <= ACCESS;
          owner <= dma_win;
          bus_address <= win_addr;
          bus_data_out <= dma_win ? dma_data_in : cpu_data_in;
          we <= dma_win ? dma_write_enable : cpu_write_enable;
          first <= 1'b1;
          wait_cnt <= bank_wait;
          // a losing DMA request implies the CPU also requested
          starve_cnt <= dma_win ? '0 : (dma_req && starve_cnt != SLIM) ? starve_cnt + 1'b1 : starve_cnt;
        end
        ACCESS: begin
          first <= 1'b0;
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
          else begin
            state <= DONE;
            if (!we && owner) dma_data_out <= bus_data_in;
            if (!we && !owner) cpu_data_out <= bus_data_in;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: scoreboard-driven checks of arbitration, wait states, strobes and reset
module tb_memory_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  logic cpu_req = 1'b0, cpu_write_enable = 1'b0, cpu_ready;
  logic [15:0] cpu_address = '0;
  logic [7:0] cpu_data_in = '0, cpu_data_out;
  logic dma_req = 1'b0, dma_write_enable = 1'b0, dma_ready;
  logic [15:0] dma_address = '0;
  logic [7:0] dma_data_in = '0, dma_data_out;
  logic [15:0] bus_address;
  logic [7:0] bus_data_out, bus_data_in;
  logic bus_write_enable, bus_busy, bus_owner;
  logic fixed_en = 1'b1;
  logic [7:0] fixed_val = '0;
  int vec = 0, mis = 0;
  typedef struct packed {logic owner; logic [7:0] data;} exp_t;
  exp_t sb[$];
  assign bus_data_in = fixed_en ? fixed_val : bus_address[7:0] + 8'h11;
  always #5 clk = ~clk;
  memory_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_data_in(cpu_data_in),
    .cpu_write_enable(cpu_write_enable), .cpu_data_out(cpu_data_out), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_address(dma_address), .dma_data_in(dma_data_in),
    .dma_write_enable(dma_write_enable), .dma_data_out(dma_data_out), .dma_ready(dma_ready),
    .bus_address(bus_address), .bus_data_out(bus_data_out), .bus_write_enable(bus_write_enable),
    .bus_data_in(bus_data_in), .bus_busy(bus_busy), .bus_owner(bus_owner)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(input int max, output int n, output logic c, output logic d);
    n = -1;
    c = 1'b0;
    d = 1'b0;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (cpu_ready || dma_ready) begin
        n = i;
        c = cpu_ready;
        d = dma_ready;
        break;
      end
    end
  endtask
  task automatic test_reset;
    tick();
    tick();
    vec++;
    if ({cpu_data_out, dma_data_out, cpu_ready, dma_ready, bus_address, bus_data_out,
         bus_write_enable, bus_busy, bus_owner} !== 45'd0) begin
      mis++;
      $display("FAIL reset_outputs got %h/%h/%h required all zero", bus_address, cpu_data_out, bus_busy);
    end
    reset = 1'b1;
    tick();
    vec++;
    if (bus_busy !== 1'b0) begin mis++; $display("FAIL reset_idle busy got %b required 0", bus_busy); end
  endtask
  task automatic test_cpu_read;
    int n; logic c, d; exp_t e;
    fixed_en = 1'b1; fixed_val = 8'h3C;
    cpu_address = 16'h0005; cpu_write_enable = 1'b0; cpu_req = 1'b1;
    sb.push_back({1'b0, 8'h3C});
    tick();
    vec++;
    if ({bus_busy, bus_owner, bus_address, bus_write_enable} !== {1'b1, 1'b0, 16'h0005, 1'b0}) begin
      mis++; $display("FAIL read_cycle1 got busy=%b own=%b addr=%h we=%b required 1 0 0005 0", bus_busy, bus_owner, bus_address, bus_write_enable);
    end
    wait_ready(4, n, c, d);
    cpu_req = 1'b0;
    vec++;
    if (n !== 1 || {c, d} !== 2'b10) begin mis++; $display("FAIL read_ready got n=%0d c=%b d=%b required n=1 c=1 d=0", n, c, d); end
    e = sb.pop_front();
    vec++;
    if (cpu_data_out !== e.data) begin mis++; $display("FAIL read_data got %h required %h", cpu_data_out, e.data); end
    tick();
    vec++;
    if ({cpu_ready, dma_ready} !== 2'b00) begin mis++; $display("FAIL read_pulse_width got %b required 00", {cpu_ready, dma_ready}); end
  endtask
  task automatic test_cpu_write;
    exp_t e;
    cpu_address = 16'h8001; cpu_data_in = 8'hA5; cpu_write_enable = 1'b1; cpu_req = 1'b1;
    sb.push_back({1'b0, 8'h3C});
    tick();
    vec++;
    if ({bus_write_enable, bus_data_out, bus_address} !== {1'b1, 8'hA5, 16'h8001}) begin
      mis++; $display("FAIL write_strobe got we=%b d=%h a=%h required 1 a5 8001", bus_write_enable, bus_data_out, bus_address);
    end
    tick();
    vec++;
    if ({bus_write_enable, cpu_ready, bus_busy} !== 3'b001) begin
      mis++; $display("FAIL write_wait got we=%b rdy=%b busy=%b required 0 0 1", bus_write_enable, cpu_ready, bus_busy);
    end
    tick();
    cpu_req = 1'b0;
    vec++;
    if ({cpu_ready, dma_ready} !== 2'b10) begin mis++; $display("FAIL write_ready got %b required 10", {cpu_ready, dma_ready}); end
    e = sb.pop_front();
    vec++;
    if (cpu_data_out !== e.data) begin mis++; $display("FAIL write_data_out got %h required %h", cpu_data_out, e.data); end
    tick();
    vec++;
    if (bus_busy !== 1'b0) begin mis++; $display("FAIL write_idle busy got %b required 0", bus_busy); end
  endtask
  task automatic test_starve;
    int n; logic c, d; exp_t e;
    logic [7:0] ord;
    logic [7:0] got;
    ord = 8'b1000_1000;
    fixed_en = 1'b0;
    cpu_address = 16'h0010; cpu_write_enable = 1'b0;
    dma_address = 16'h0020; dma_write_enable = 1'b0;
    for (int i = 0; i < 8; i++) sb.push_back({ord[i], ord[i] ? 8'h31 : 8'h21});
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_ready(6, n, c, d);
      if (i == 7) begin cpu_req = 1'b0; dma_req = 1'b0; end
      vec++;
      if (n < 0 || {c, d} !== {~ord[i], ord[i]}) begin
        mis++; $display("FAIL grant_%0d got n=%0d c=%b d=%b required d=%b", i, n, c, d, ord[i]);
      end
      e = sb.pop_front();
      got = d ? dma_data_out : cpu_data_out;
      vec++;
      if ({d, got} !== {e.owner, e.data}) begin
        mis++; $display("FAIL grant_data_%0d got %b/%h required %b/%h", i, d, got, e.owner, e.data);
      end
    end
    tick();
  endtask
  task automatic test_back_to_back;
    int n; logic c, d; exp_t e;
    fixed_en = 1'b0;
    dma_address = 16'h4000; dma_write_enable = 1'b0; dma_req = 1'b1;
    sb.push_back({1'b1, 8'h11});
    sb.push_back({1'b1, 8'h12});
    wait_ready(6, n, c, d);
    dma_address = 16'h4001;
    vec++;
    if (n !== 2 || {c, d} !== 2'b01) begin mis++; $display("FAIL b2b_first got n=%0d c=%b d=%b required 2 0 1", n, c, d); end
    e = sb.pop_front();
    vec++;
    if (dma_data_out !== e.data) begin mis++; $display("FAIL b2b_data1 got %h required %h", dma_data_out, e.data); end
    wait_ready(6, n, c, d);
    dma_req = 1'b0;
    vec++;
    if (n !== 3 || {c, d} !== 2'b01) begin mis++; $display("FAIL b2b_second got n=%0d c=%b d=%b required 3 0 1", n, c, d); end
    e = sb.pop_front();
    vec++;
    if (dma_data_out !== e.data) begin mis++; $display("FAIL b2b_data2 got %h required %h", dma_data_out, e.data); end
    tick();
    vec++;
    if (dma_ready !== 1'b0) begin mis++; $display("FAIL b2b_pulse got %b required 0", dma_ready); end
  endtask
  task automatic test_reset_mid;
    int n; logic c, d; exp_t e;
    fixed_en = 1'b1; fixed_val = 8'h9E;
    cpu_address = 16'h8002; cpu_data_in = 8'h77; cpu_write_enable = 1'b1; cpu_req = 1'b1;
    tick();
    tick();
    vec++;
    if ({bus_busy, bus_address} !== {1'b1, 16'h8002}) begin mis++; $display("FAIL midrst_access got busy=%b a=%h required 1 8002", bus_busy, bus_address); end
    reset = 1'b0;
    #1;
    vec++;
    if ({cpu_data_out, dma_data_out, cpu_ready, dma_ready, bus_address, bus_data_out,
         bus_write_enable, bus_busy, bus_owner} !== 45'd0) begin
      mis++; $display("FAIL midrst_outputs got a=%h d=%h busy=%b dma=%h required all zero", bus_address, bus_data_out, bus_busy, dma_data_out);
    end
    cpu_req = 1'b0;
    repeat (3) tick();
    vec++;
    if ({cpu_ready, dma_ready, bus_busy} !== 3'b000) begin mis++; $display("FAIL midrst_hold got %b required 000", {cpu_ready, dma_ready, bus_busy}); end
    reset = 1'b1;
    cpu_address = 16'h0003; cpu_write_enable = 1'b0; cpu_req = 1'b1;
    sb.push_back({1'b0, 8'h9E});
    wait_ready(6, n, c, d);
    cpu_req = 1'b0;
    vec++;
    if (n !== 2 || {c, d} !== 2'b10) begin mis++; $display("FAIL midrst_fresh got n=%0d c=%b d=%b required 2 1 0", n, c, d); end
    e = sb.pop_front();
    vec++;
    if (cpu_data_out !== e.data) begin mis++; $display("FAIL midrst_data got %h required %h", cpu_data_out, e.data); end
    tick();
  endtask
  task automatic test_bank3;
    int n; logic c, d; exp_t e;
    fixed_en = 1'b1; fixed_val = 8'h00;
    cpu_address = 16'hC000; cpu_write_enable = 1'b0; cpu_req = 1'b1;
    sb.push_back({1'b0, 8'h00});
    wait_ready(6, n, c, d);
    cpu_req = 1'b0;
    vec++;
    if (n !== 2 || {c, d} !== 2'b10) begin mis++; $display("FAIL bank3_ready got n=%0d c=%b d=%b required 2 1 0", n, c, d); end
    e = sb.pop_front();
    vec++;
    if (cpu_data_out !== e.data) begin mis++; $display("FAIL bank3_data got %h required %h", cpu_data_out, e.data); end
    tick();
  endtask
  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_starve();
    test_back_to_back();
    test_reset_mid();
    test_bank3();
    vec++;
    if (sb.size() !== 0) begin mis++; $display("FAIL scoreboard_left got %0d required 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
